// File: rtl/fetch_pc_if.sv
// Fetch-PC bundle: hazard/next-PC side drives enable and redirects, PC register returns fetch state.
interface fetch_pc_if #(
    parameter int XLEN = 32
);
    logic            enable;
    logic            redir_ex_valid;
    logic [XLEN-1:0] redir_ex_target;
    logic            redir_id_valid;
    logic [XLEN-1:0] redir_id_target;
    logic [XLEN-1:0] pc_f;
    logic            redirect_taken;
    logic            misalign;
    logic            pend_valid;

    modport master (
        output enable, redir_ex_valid, redir_ex_target, redir_id_valid, redir_id_target,
        input  pc_f, redirect_taken, misalign, pend_valid
    );

    modport slave (
        input  enable, redir_ex_valid, redir_ex_target, redir_id_valid, redir_id_target,
        output pc_f, redirect_taken, misalign, pend_valid
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register: sequential advance, EX>ID>pending redirect priority, misaligned targets flagged and cleared.
// Latency 1 edge from redirect to pc_f; enable=0 stalls pc_f and parks one redirect until enable returns.
module fetch_pc_ctrl #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(32'h00400020),
    parameter int              INSN_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    fetch_pc_if.slave  pif
);
    typedef enum logic {
        SRC_EX = 1'b0,
        SRC_ID = 1'b1
    } src_e;

    localparam logic [XLEN-1:0] STEP       = XLEN'(INSN_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSN_BYTES - 1);

    logic [XLEN-1:0] pc_q;
    logic            redirect_q;
    logic            misalign_q;
    logic            pend_valid_q;
    logic [XLEN-1:0] pend_target_q;
    src_e            pend_src_q;

    logic [XLEN-1:0] sel_target;
    logic            sel_redirect;
    logic [XLEN-1:0] next_pc;
    logic            next_misalign;
    logic            id_blocked;
    logic            cap_ex;
    logic            cap_id;

    // A parked EX redirect is older and architecturally ahead of any ID jump.
    assign id_blocked = pend_valid_q && (pend_src_q == SRC_EX);

    always_comb begin
        sel_target   = pc_q + STEP;
        sel_redirect = 1'b0;
        if (pif.redir_ex_valid) begin
            sel_target   = pif.redir_ex_target;
            sel_redirect = 1'b1;
        end else if (pif.redir_id_valid && !id_blocked) begin
            sel_target   = pif.redir_id_target;
            sel_redirect = 1'b1;
        end else if (pend_valid_q) begin
            sel_target   = pend_target_q;
            sel_redirect = 1'b1;
        end
        next_pc       = sel_redirect ? (sel_target & ~ALIGN_MASK) : sel_target;
        next_misalign = sel_redirect && ((sel_target & ALIGN_MASK) != '0);
    end

    assign cap_ex = pif.redir_ex_valid;
    assign cap_id = pif.redir_id_valid && !pif.redir_ex_valid && !id_blocked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            redirect_q    <= 1'b0;
            misalign_q    <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            pend_src_q    <= SRC_EX;
        end else if (pif.enable) begin
            pc_q         <= next_pc;
            misalign_q   <= next_misalign;
            redirect_q   <= sel_redirect;
            pend_valid_q <= 1'b0;
        end else begin
            redirect_q <= 1'b0;
            if (cap_ex) begin
                pend_valid_q  <= 1'b1;
                pend_target_q <= pif.redir_ex_target;
                pend_src_q    <= SRC_EX;
            end else if (cap_id) begin
                pend_valid_q  <= 1'b1;
                pend_target_q <= pif.redir_id_target;
                pend_src_q    <= SRC_ID;
            end
        end
    end

    assign pif.pc_f           = pc_q;
    assign pif.redirect_taken = redirect_q;
    assign pif.misalign       = misalign_q;
    assign pif.pend_valid     = pend_valid_q;
endmodule
